// File: rtl/store_buffer_if.sv
// Store request, load-check and data-memory write bundle for store_buffer.
// master = pipeline/memory side, slave = the store buffer.
interface store_buffer_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_ready;
    logic        st_err;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        empty;

    modport master (
        output st_valid, st_addr, st_data, st_funct3,
        output ld_check, ld_addr, mem_ack,
        input  st_ready, st_err, ld_conflict,
        input  mem_we, mem_addr, mem_wdata, mem_be, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3,
        input  ld_check, ld_addr, mem_ack,
        output st_ready, st_err, ld_conflict,
        output mem_we, mem_addr, mem_wdata, mem_be, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: aligns SB/SH/SW into byte lanes, queues them in a FIFO,
// drains to data memory and flags loads that hit a pending store word.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    store_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [29:0] wa;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t        state_q, state_d;
    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;

    logic          is_sb, is_sh, is_sw;
    logic          legal, full, enq, pop;
    logic [31:0]   al_data;
    logic [3:0]    al_be;
    logic [DEPTH-1:0] hit;
    logic          unused_ok;

    assign is_sb = bus.st_funct3 == 3'b000;
    assign is_sh = bus.st_funct3 == 3'b001;
    assign is_sw = bus.st_funct3 == 3'b010;

    always_comb begin
        legal   = 1'b0;
        al_data = '0;
        al_be   = '0;
        unique case (1'b1)
            is_sb: begin
                legal   = 1'b1;
                al_be   = 4'b0001 << bus.st_addr[1:0];
                al_data = {4{bus.st_data[7:0]}};
            end
            is_sh: begin
                legal   = ~bus.st_addr[0];
                al_be   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                al_data = {2{bus.st_data[15:0]}};
            end
            is_sw: begin
                legal   = bus.st_addr[1:0] == 2'b00;
                al_be   = 4'b1111;
                al_data = bus.st_data;
            end
            default: ;
        endcase
    end

    assign full = count_q == CW'(DEPTH);
    assign enq  = bus.st_valid && !full && legal;
    assign pop  = (state_q == WRITE) && bus.mem_ack;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = bus.st_valid && !full && !legal;
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        if (enq) begin
            fifo_d[wr_ptr_q] = '{wa: bus.st_addr[31:2], data: al_data, be: al_be};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(enq) - CW'(pop);
        // The head stays queued while in flight so loads still see it.
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    addr_d  = {fifo_q[rd_ptr_q].wa, 2'b00};
                    wdata_d = fifo_q[rd_ptr_q].data;
                    be_d    = fifo_q[rd_ptr_q].be;
                    we_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.mem_ack) begin
                    we_d    = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] off;
            off = AW'(i) - rd_ptr_q;
            hit[i] = ({1'b0, off} < count_q) &&
                     (fifo_q[i].wa == bus.ld_addr[31:2]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else begin
            fifo_q   <= fifo_d;
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    assign bus.st_ready    = !full;
    assign bus.st_err      = err_q;
    assign bus.empty       = count_q == '0;
    assign bus.ld_conflict = bus.ld_check && |hit;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_be      = be_q;

    assign unused_ok = &{1'b0, bus.ld_addr[1:0]};
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: alignment, rejection, backpressure,
// load conflict and asynchronous reset during a write.
module tb_store_buffer;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    store_buffer_if bus ();

    store_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f);
        bus.st_valid  = 1'b1;
        bus.st_addr   = a;
        bus.st_data   = d;
        bus.st_funct3 = f;
        tick();
        bus.st_valid  = 1'b0;
    endtask

    task automatic ack_one();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
    endtask

    logic [31:0] bad_a [3];
    logic [2:0]  bad_f [3];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.st_funct3 = '0;
        bus.ld_check  = 1'b1;
        bus.ld_addr   = '0;
        bus.mem_ack   = 1'b0;
        #12;
        chk("rst_ready", 32'(bus.st_ready), 32'd1);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_err", 32'(bus.st_err), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_be", 32'(bus.mem_be), 32'h0);
        chk("rst_conf", 32'(bus.ld_conflict), 32'd0);
        bus.ld_check = 1'b0;
        rst_n = 1'b1;
        tick();

        // SW with ack held high
        bus.mem_ack = 1'b1;
        put(32'h100, 32'hDEADBEEF, 3'b010);
        chk("sw_notempty", 32'(bus.empty), 32'd0);
        chk("sw_we_lat0", 32'(bus.mem_we), 32'd0);
        tick();
        chk("sw_we", 32'(bus.mem_we), 32'd1);
        chk("sw_addr", bus.mem_addr, 32'h100);
        chk("sw_be", 32'(bus.mem_be), 32'hF);
        chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
        tick();
        bus.mem_ack = 1'b0;
        chk("sw_we_off", 32'(bus.mem_we), 32'd0);
        chk("sw_empty", 32'(bus.empty), 32'd1);

        // SB at 0x203
        put(32'h203, 32'h000000A5, 3'b000);
        tick();
        chk("sb_addr", bus.mem_addr, 32'h200);
        chk("sb_be", 32'(bus.mem_be), 32'h8);
        chk("sb_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        ack_one();
        chk("sb_empty", 32'(bus.empty), 32'd1);

        // SH at 0x206, upper half of data must be ignored
        put(32'h206, 32'hABCD1234, 3'b001);
        tick();
        chk("sh_addr", bus.mem_addr, 32'h204);
        chk("sh_be", 32'(bus.mem_be), 32'hC);
        chk("sh_wdata", bus.mem_wdata, 32'h12341234);
        ack_one();
        chk("sh_empty", 32'(bus.empty), 32'd1);
        tick();

        // rejected stores
        bad_a[0] = 32'h102; bad_f[0] = 3'b010;
        bad_a[1] = 32'h101; bad_f[1] = 3'b001;
        bad_a[2] = 32'h100; bad_f[2] = 3'b011;
        for (int i = 0; i < 3; i++) begin
            put(bad_a[i], 32'h55, bad_f[i]);
            chk($sformatf("rej%0d_err", i), 32'(bus.st_err), 32'd1);
            chk($sformatf("rej%0d_empty", i), 32'(bus.empty), 32'd1);
            tick();
            chk($sformatf("rej%0d_errclr", i), 32'(bus.st_err), 32'd0);
            chk($sformatf("rej%0d_we", i), 32'(bus.mem_we), 32'd0);
        end

        // backpressure: four stores fill the buffer
        for (int i = 0; i < 4; i++) begin
            put(32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 3'b010);
            chk($sformatf("fill%0d_ready", i), 32'(bus.st_ready),
                (i == 3) ? 32'd0 : 32'd1);
        end
        bus.st_valid  = 1'b1;
        bus.st_addr   = 32'h500;
        bus.st_data   = 32'h2000;
        bus.st_funct3 = 3'b010;
        tick();
        chk("full_err", 32'(bus.st_err), 32'd0);
        chk("full_ready", 32'(bus.st_ready), 32'd0);
        bus.st_valid = 1'b0;
        bus.mem_ack  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_we", i), 32'(bus.mem_we), 32'd1);
            chk($sformatf("drain%0d_addr", i), bus.mem_addr,
                32'h400 + 32'(4 * i));
            chk($sformatf("drain%0d_data", i), bus.mem_wdata,
                32'h1000 + 32'(i));
            tick();
            chk($sformatf("drain%0d_gap", i), 32'(bus.mem_we), 32'd0);
            tick();
        end
        bus.mem_ack = 1'b0;
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_idle", 32'(bus.mem_we), 32'd0);

        // load conflict
        put(32'h301, 32'h77, 3'b000);
        bus.ld_addr  = 32'h300;
        bus.ld_check = 1'b0;
        #1;
        chk("ld_nocheck", 32'(bus.ld_conflict), 32'd0);
        bus.ld_check = 1'b1;
        #1;
        chk("ld_hit", 32'(bus.ld_conflict), 32'd1);
        bus.ld_addr = 32'h304;
        #1;
        chk("ld_miss", 32'(bus.ld_conflict), 32'd0);
        bus.ld_addr = 32'h302;
        #1;
        chk("ld_hit_word", 32'(bus.ld_conflict), 32'd1);
        tick();
        bus.ld_addr = 32'h300;
        #1;
        chk("ld_inflight_we", 32'(bus.mem_we), 32'd1);
        chk("ld_inflight", 32'(bus.ld_conflict), 32'd1);
        ack_one();
        chk("ld_retired", 32'(bus.ld_conflict), 32'd0);
        bus.ld_check = 1'b0;
        tick();

        // asynchronous reset during WRITE
        put(32'h600, 32'hAAAA0001, 3'b010);
        put(32'h604, 32'hAAAA0002, 3'b010);
        put(32'h608, 32'hAAAA0003, 3'b010);
        chk("mid_we_pre", 32'(bus.mem_we), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_we", 32'(bus.mem_we), 32'd0);
        chk("mid_be", 32'(bus.mem_be), 32'h0);
        chk("mid_addr", bus.mem_addr, 32'h0);
        chk("mid_wdata", bus.mem_wdata, 32'h0);
        tick();
        rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        chk("post_empty", 32'(bus.empty), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_we%0d", i), 32'(bus.mem_we), 32'd0);
        end
        bus.mem_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
